// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - state encoding and default widths for dmem_responder
package dmem_responder_pkg;

  localparam int DEF_DW         = 16;
  localparam int DEF_AW         = 16;
  localparam int DEF_DEPTH_LOG2 = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant relative to a last-grant pointer
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            cand_int;
  logic [IW-1:0] cand;

  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand_int = 0;
    cand     = '0;
    // Scan starting just after the previous winner so it ends up lowest priority.
    for (int k = 1; k <= N; k++) begin
      cand_int = (int'(last) + k) % N;
      cand     = IW'(cand_int);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - round-robin shared data-memory responder over a single-port sync RAM
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int NCORES     = 2,
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    mem_rd,
  input  logic [NCORES-1:0]    mem_wr,
  input  logic [NCORES*AW-1:0] addr,
  input  logic [NCORES*DW-1:0] wdata,
  output logic [NCORES*DW-1:0] rdata,
  output logic [NCORES-1:0]    ack,
  output logic                 busy
);

  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  state_t                state, state_next;
  logic [NCORES-1:0]     req, arb_grant, g_onehot;
  logic [IW-1:0]         ptr, arb_idx, g_idx;
  logic                  arb_any;
  logic                  g_wr;
  logic [DEPTH_LOG2-1:0] g_addr;
  logic [DW-1:0]         g_wdata;
  logic [DW-1:0]         ram_q;
  logic [DW-1:0]         ram [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] addr_lo [NCORES];
  logic [DW-1:0]         wdata_a [NCORES];
  logic [DW-1:0]         rdata_a [NCORES];
  logic                  unused_addr;

  for (genvar i = 0; i < NCORES; i++) begin : g_core
    assign addr_lo[i]           = addr[i*AW +: DEPTH_LOG2];
    assign wdata_a[i]           = wdata[i*DW +: DW];
    assign rdata[i*DW +: DW]    = rdata_a[i];
  end

  // Upper address bits alias onto the RAM; fold them into a sink.
  assign unused_addr = ^addr;

  assign req = mem_rd | mem_wr;

  rr_arbiter #(
    .N  (NCORES),
    .IW (IW)
  ) u_arb (
    .req   (req),
    .last  (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ack        = '0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:   if (arb_any) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP: begin
        state_next = ST_IDLE;
        // Reset in the response cycle suppresses the pulse.
        if (!rst) ack = g_onehot;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= IW'(NCORES - 1);
      g_idx    <= '0;
      g_onehot <= '0;
      g_wr     <= 1'b0;
      g_addr   <= '0;
      g_wdata  <= '0;
      for (int i = 0; i < NCORES; i++) rdata_a[i] <= '0;
    end else begin
      if (state == ST_IDLE && arb_any) begin
        g_idx    <= arb_idx;
        g_onehot <= arb_grant;
        g_wr     <= mem_wr[arb_idx];
        g_addr   <= addr_lo[arb_idx];
        g_wdata  <= wdata_a[arb_idx];
      end
      if (state == ST_RESP) begin
        ptr <= g_idx;
        if (!g_wr) rdata_a[g_idx] <= ram_q;
      end
    end
  end

  // Single port: either a write or a registered read on the ACCESS edge.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_ACCESS) begin
      if (g_wr) ram[g_addr] <= g_wdata;
      else      ram_q       <= ram[g_addr];
    end
  end

endmodule
